// File: rtl/apb_multi_slave_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_multi_slave_master
// Brief    : APB4 master that queues host requests in a FIFO and decodes PSEL
//            from the top address bits. Runs back-to-back transfers and aborts
//            stalled accesses after a wait-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_multi_slave_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic                            transfer,
    output logic                            req_ready,
    input  logic                            write_read,
    input  logic [ADDR_WIDTH-1:0]           addr_in,
    input  logic [DATA_WIDTH-1:0]           wdata_in,
    input  logic [DATA_WIDTH/8-1:0]         strb_in,
    output logic [ADDR_WIDTH-1:0]           PADDR,
    output logic [NUM_SLAVES-1:0]           PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    output logic [DATA_WIDTH/8-1:0]         PSTRB,
    input  logic [DATA_WIDTH-1:0]           PRDATA,
    input  logic                            PREADY,
    input  logic                            PSLVERR,
    output logic [DATA_WIDTH-1:0]           rdata_out,
    output logic                            transfer_done,
    output logic                            error,
    output logic                            timeout,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int c_STRB_W   = DATA_WIDTH / 8;
    localparam int c_SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 0;
    localparam int c_IDX_W    = (c_SEL_BITS > 0) ? c_SEL_BITS : 1;
    localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W    = c_PTR_W + 1;
    localparam int c_ENT_W    = ADDR_WIDTH + 1 + DATA_WIDTH + c_STRB_W;
    localparam int c_TO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0]    fifo_mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    wr_ptr_q;
    logic [c_PTR_W-1:0]    rd_ptr_q;
    logic [c_CNT_W-1:0]    count_q;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic                  w_head_write;
    logic [DATA_WIDTH-1:0] w_head_wdata;
    logic [c_STRB_W-1:0]   w_head_strb;

    assign w_full  = (count_q == c_CNT_W'(FIFO_DEPTH));
    assign w_empty = (count_q == '0);
    // A full FIFO refuses the push even when the same cycle frees a slot.
    assign w_push  = transfer && !w_full;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_push) fifo_mem_q[wr_ptr_q] <= {addr_in, write_read, wdata_in, strb_in};
    end

    assign {w_head_addr, w_head_write, w_head_wdata, w_head_strb} = fifo_mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Slave decode of the FIFO head
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_idx;
    logic               w_idx_valid;
    logic               w_head_ok;

    generate
        if (c_SEL_BITS == 0) begin : g_single_slave
            assign w_idx = '0;
        end else begin : g_multi_slave
            assign w_idx = w_head_addr[ADDR_WIDTH-1 -: c_IDX_W];
        end
    endgenerate

    assign w_idx_valid = ({{(32 - c_IDX_W){1'b0}}, w_idx} < 32'(NUM_SLAVES));
    assign w_head_ok   = !w_empty && w_idx_valid;

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [c_STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  timeout_q, timeout_d;
    logic [c_TO_W-1:0]     tocnt_q, tocnt_d;
    logic                  w_finish;
    logic                  w_load;
    logic                  w_to_hit;

    assign w_to_hit = (TIMEOUT_CYCLES != 0) && (tocnt_q == c_TO_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            paddr_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            tocnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            tocnt_q   <= tocnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        timeout_d = 1'b0;
        tocnt_d   = tocnt_q;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_finish  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_idx_valid) begin
                        w_load = 1'b1;
                    end else begin
                        // Undecodable address: retire it without touching the bus.
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
                tocnt_d   = '0;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    done_d   = 1'b1;
                    error_d  = PSLVERR;
                    w_finish = 1'b1;
                    if (!pwrite_q) rdata_d = PRDATA;
                end else if (w_to_hit) begin
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    w_finish  = 1'b1;
                    if (!pwrite_q) rdata_d = '0;
                end else begin
                    tocnt_d = tocnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Chain straight into the next SETUP when a decodable request waits.
        if (w_finish) begin
            if (w_head_ok) begin
                w_pop  = 1'b1;
                w_load = 1'b1;
            end else begin
                state_d   = S_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        end

        if (w_load) begin
            state_d   = S_SETUP;
            paddr_d   = w_head_addr;
            psel_d    = NUM_SLAVES'(1) << w_idx;
            penable_d = 1'b0;
            pwrite_d  = w_head_write;
            pwdata_d  = w_head_write ? w_head_wdata : '0;
            pstrb_d   = w_head_write ? w_head_strb  : '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, forced low while reset is asserted
    // ------------------------------------------------------------------
    assign req_ready     = PRESET | !w_full;
    assign PADDR         = PRESET ? '0   : paddr_q;
    assign PSEL          = PRESET ? '0   : psel_q;
    assign PENABLE       = !PRESET && penable_q;
    assign PWRITE        = !PRESET && pwrite_q;
    assign PWDATA        = PRESET ? '0   : pwdata_q;
    assign PSTRB         = PRESET ? '0   : pstrb_q;
    assign rdata_out     = PRESET ? '0   : rdata_q;
    assign transfer_done = !PRESET && done_q;
    assign error         = !PRESET && error_q;
    assign timeout       = !PRESET && timeout_q;
    assign fifo_count    = PRESET ? '0   : count_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_multi_slave_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_multi_slave_master
// Brief    : Self-checking bench for apb_multi_slave_master (3 slaves, 4-deep
//            FIFO, 16-cycle timeout) with a scoreboard of expected completions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_multi_slave_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer;
    logic        req_ready;
    logic        write_read;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [3:0]  strb_in;
    logic [31:0] PADDR;
    logic [2:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] rdata_out;
    logic        transfer_done;
    logic        error;
    logic        timeout;
    logic [2:0]  fifo_count;

    apb_multi_slave_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .NUM_SLAVES    (3),
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .transfer     (transfer),
        .req_ready    (req_ready),
        .write_read   (write_read),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .strb_in      (strb_in),
        .PADDR        (PADDR),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PWDATA       (PWDATA),
        .PSTRB        (PSTRB),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .rdata_out    (rdata_out),
        .transfer_done(transfer_done),
        .error        (error),
        .timeout      (timeout),
        .fifo_count   (fifo_count)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge PCLK) cyc++;

    // Slave model: PREADY after slv_wait stalled ACCESS cycles, data = PADDR ^ slv_xor
    int          slv_wait  = 0;
    logic        slv_stall = 1'b0;
    logic        slv_err   = 1'b0;
    logic [31:0] slv_xor   = 32'h0;
    int          acc_cnt   = 0;

    always @(negedge PCLK) begin
        if (PSEL != 3'b000 && PENABLE === 1'b1) begin
            PREADY  = (acc_cnt >= slv_wait) && !slv_stall;
            PRDATA  = PADDR ^ slv_xor;
            PSLVERR = slv_err;
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            PRDATA  = 32'h0;
            PSLVERR = 1'b0;
            acc_cnt = 0;
        end
    end

    typedef struct {
        logic        is_read;
        logic        err;
        logic        to;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model_rdata = 32'h0;

    always @(negedge PCLK) begin
        if (PRESET === 1'b0) begin
            if (transfer_done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done: transfer_done=1 with no request outstanding (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (error !== mon_e.err || timeout !== mon_e.to) begin
                        errors++;
                        $display("FAIL sb_status: got error=%b timeout=%b, expected error=%b timeout=%b (cycle %0d)",
                                 error, timeout, mon_e.err, mon_e.to, cyc);
                    end
                    if (mon_e.chk) begin
                        if (mon_e.is_read) model_rdata = mon_e.to ? 32'h0 : mon_e.rdata;
                        checks++;
                        if (rdata_out !== model_rdata) begin
                            errors++;
                            $display("FAIL sb_rdata: got rdata_out=%h, expected %h (cycle %0d)", rdata_out, model_rdata, cyc);
                        end
                    end
                end
            end else begin
                checks++;
                if (error !== 1'b0 || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL qual_without_done: error=%b timeout=%b while transfer_done=0 (cycle %0d)", error, timeout, cyc);
                end
            end
        end
    end

    // Called at a negedge; the request is pushed at the following posedge.
    task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic e_err, input logic e_to, input logic e_chk, input logic [31:0] e_rd,
                       input logic to_sb);
        exp_t e;
        e.is_read = !wr;
        e.err     = e_err;
        e.to      = e_to;
        e.chk     = e_chk;
        e.rdata   = e_rd;
        if (to_sb) sb.push_back(e);
        transfer   = 1'b1;
        write_read = wr;
        addr_in    = a;
        wdata_in   = d;
        strb_in    = s;
        @(negedge PCLK);
        transfer   = 1'b0;
        write_read = 1'b0;
        addr_in    = 32'h0;
        wdata_in   = 32'h0;
        strb_in    = 4'h0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        transfer = 1'b0; write_read = 1'b0; addr_in = 32'h0; wdata_in = 32'h0; strb_in = 4'h0;
        repeat (3) @(negedge PCLK);
        checks++;
        if (PSEL !== 3'b000 || PENABLE !== 1'b0 || PADDR !== 32'h0 || PWRITE !== 1'b0 ||
            PWDATA !== 32'h0 || PSTRB !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus: PSEL=%b PENABLE=%b PADDR=%h PWRITE=%b PWDATA=%h PSTRB=%h, expected all 0",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB);
        end
        checks++;
        if (transfer_done !== 1'b0 || error !== 1'b0 || timeout !== 1'b0 || rdata_out !== 32'h0 ||
            fifo_count !== 3'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: done=%b error=%b timeout=%b rdata=%h count=%0d ready=%b, expected 0/0/0/0/0/1",
                     transfer_done, error, timeout, rdata_out, fifo_count, req_ready);
        end
        PRESET = 1'b0;
        @(negedge PCLK);
        checks++;
        if (PSEL !== 3'b000 || fifo_count !== 3'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: PSEL=%b count=%0d ready=%b, expected 000/0/1", PSEL, fifo_count, req_ready);
        end
    endtask

    task automatic test_write();
        slv_wait = 0; slv_stall = 1'b0; slv_err = 1'b0;
        req(1'b1, 32'h1000_0004, 32'hA5A5_5A5A, 4'hF, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
        checks++;
        if (fifo_count !== 3'd1 || PSEL !== 3'b000) begin
            errors++;
            $display("FAIL write_queued: count=%0d PSEL=%b, expected 1/000", fifo_count, PSEL);
        end
        @(negedge PCLK);
        checks++;
        if (PSEL !== 3'b001 || PENABLE !== 1'b0 || PADDR !== 32'h1000_0004 || PWRITE !== 1'b1 ||
            PWDATA !== 32'hA5A5_5A5A || PSTRB !== 4'hF) begin
            errors++;
            $display("FAIL write_setup: PSEL=%b PENABLE=%b PADDR=%h PWRITE=%b PWDATA=%h PSTRB=%h, expected 001/0/10000004/1/a5a55a5a/f",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB);
        end
        @(negedge PCLK);
        checks++;
        if (PSEL !== 3'b001 || PENABLE !== 1'b1 || PADDR !== 32'h1000_0004 || PWDATA !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL write_access: PSEL=%b PENABLE=%b PADDR=%h PWDATA=%h, expected 001/1/10000004/a5a55a5a",
                     PSEL, PENABLE, PADDR, PWDATA);
        end
        @(negedge PCLK);
        checks++;
        if (transfer_done !== 1'b1 || error !== 1'b0 || PSEL !== 3'b000 || PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL write_done_latency: done=%b error=%b PSEL=%b PENABLE=%b, expected 1/0/000/0",
                     transfer_done, error, PSEL, PENABLE);
        end
        @(negedge PCLK);
        checks++;
        if (transfer_done !== 1'b0) begin
            errors++;
            $display("FAIL write_done_pulse: done=%b one cycle later, expected 0", transfer_done);
        end
    endtask

    task automatic test_read_wait();
        int  acc = 0;
        bit  got = 0;
        slv_wait = 3;
        slv_xor  = 32'hDEAD_BEEF ^ 32'h4000_0000;
        req(1'b0, 32'h4000_0000, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        @(negedge PCLK);
        checks++;
        if (PSEL !== 3'b010 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PSTRB !== 4'h0 || PWDATA !== 32'h0) begin
            errors++;
            $display("FAIL read_setup: PSEL=%b PENABLE=%b PWRITE=%b PSTRB=%h PWDATA=%h, expected 010/0/0/0/0",
                     PSEL, PENABLE, PWRITE, PSTRB, PWDATA);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (transfer_done === 1'b1) begin
                got = 1;
                break;
            end
            if (PENABLE === 1'b1) acc++;
        end
        checks++;
        if (!got || acc != 4 || rdata_out !== 32'hDEAD_BEEF || error !== 1'b0) begin
            errors++;
            $display("FAIL read_wait: done=%0d access_cycles=%0d rdata=%h error=%b, expected 1/4/deadbeef/0",
                     got, acc, rdata_out, error);
        end
        slv_wait = 0;
    endtask

    task automatic test_slverr();
        bit got = 0;
        slv_err = 1'b1;
        req(1'b1, 32'h4000_0008, 32'h0000_1111, 4'h1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge PCLK);
            if (transfer_done === 1'b1) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got || error !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL slverr: done=%0d error=%b timeout=%b, expected 1/1/0", got, error, timeout);
        end
        slv_err = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic exp_ready;
        int   bad_cnt = 0;
        slv_stall = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            exp_ready = (i <= 5);
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL fifo_ready_push%0d: req_ready=%b, expected %b", i, req_ready, exp_ready);
            end
            req(1'b1, 32'h0000_1000 + 32'(i * 4), 32'(i), 4'h3, 1'b0, 1'b0, 1'b1, 32'h0, exp_ready);
            if (fifo_count > 3'd4) bad_cnt++;
        end
        checks++;
        if (fifo_count !== 3'd4 || req_ready !== 1'b0 || bad_cnt != 0) begin
            errors++;
            $display("FAIL fifo_full: count=%0d ready=%b over_limit=%0d, expected 4/0/0", fifo_count, req_ready, bad_cnt);
        end
        slv_stall = 1'b0;
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge PCLK);
        checks++;
        if (sb.size() != 0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL fifo_drain: outstanding=%0d count=%0d, expected 0/0", sb.size(), fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] al[4];
        int n = 0, last = 0, bad_gap = 0, idle = 0;
        bit seen = 0;
        al = '{32'h0000_0010, 32'h4000_0020, 32'h0000_0030, 32'h4000_0040};
        slv_xor = 32'h1357_9BDF;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    req(1'b0, al[i], 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, al[i] ^ 32'h1357_9BDF, 1'b1);
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(negedge PCLK);
                    if (transfer_done === 1'b1) begin
                        if (n > 0 && (cyc - last) != 2) bad_gap++;
                        last = cyc;
                        n++;
                    end
                    if (PSEL !== 3'b000) seen = 1;
                    else if (seen && n < 4) idle++;
                end
            end
        join
        checks++;
        if (n != 4 || bad_gap != 0 || idle != 0) begin
            errors++;
            $display("FAIL back_to_back: done_pulses=%0d bad_gaps=%0d idle_cycles=%0d, expected 4/0/0", n, bad_gap, idle);
        end
    endtask

    task automatic test_timeout();
        int acc = 0;
        bit got = 0;
        bit got2 = 0;
        slv_stall = 1'b1;
        req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1);
        req(1'b1, 32'h4000_0200, 32'h0000_0055, 4'hF, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
        for (int k = 0; k < 60; k++) begin
            @(negedge PCLK);
            if (transfer_done === 1'b1) begin
                got = 1;
                break;
            end
            if (PENABLE === 1'b1 && PADDR === 32'h0000_0100) acc++;
        end
        checks++;
        if (!got || acc != 16 || error !== 1'b1 || timeout !== 1'b1 || rdata_out !== 32'h0) begin
            errors++;
            $display("FAIL timeout_abort: done=%0d access_cycles=%0d error=%b timeout=%b rdata=%h, expected 1/16/1/1/0",
                     got, acc, error, timeout, rdata_out);
        end
        checks++;
        if (PSEL !== 3'b010 || PENABLE !== 1'b0 || PADDR !== 32'h4000_0200) begin
            errors++;
            $display("FAIL timeout_next: PSEL=%b PENABLE=%b PADDR=%h, expected 010/0/40000200", PSEL, PENABLE, PADDR);
        end
        slv_stall = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge PCLK);
            if (transfer_done === 1'b1) begin
                got2 = 1;
                break;
            end
        end
        checks++;
        if (!got2 || error !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover: done=%0d error=%b timeout=%b, expected 1/0/0", got2, error, timeout);
        end
    endtask

    task automatic test_decode_err();
        int sel_cnt = 0;
        bit got = 0;
        req(1'b0, 32'hC000_0000, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge PCLK);
            if (PSEL !== 3'b000) sel_cnt++;
            if (transfer_done === 1'b1) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got || sel_cnt != 0 || error !== 1'b1 || timeout !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL decode_err: done=%0d psel_cycles=%0d error=%b timeout=%b count=%0d, expected 1/0/1/0/0",
                     got, sel_cnt, error, timeout, fifo_count);
        end
    endtask

    task automatic test_reset_mid();
        bit in_access = 0;
        int late_done = 0, late_sel = 0;
        slv_stall = 1'b1;
        req(1'b1, 32'h0000_0040, 32'h0000_0077, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        req(1'b1, 32'h4000_0044, 32'h0000_0088, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (PENABLE === 1'b1) begin
                in_access = 1;
                break;
            end
            @(negedge PCLK);
        end
        checks++;
        if (!in_access || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL rstmid_pre: in_access=%0d count=%0d, expected 1/1", in_access, fifo_count);
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        checks++;
        if (PSEL !== 3'b000 || PENABLE !== 1'b0 || fifo_count !== 3'd0 || transfer_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_edge: PSEL=%b PENABLE=%b count=%0d done=%b, expected 000/0/0/0",
                     PSEL, PENABLE, fifo_count, transfer_done);
        end
        @(negedge PCLK);
        PRESET    = 1'b0;
        slv_stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge PCLK);
            if (transfer_done !== 1'b0) late_done++;
            if (PSEL !== 3'b000) late_sel++;
        end
        checks++;
        if (late_done != 0 || late_sel != 0 || fifo_count !== 3'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after: done_cycles=%0d psel_cycles=%0d count=%0d ready=%b, expected 0/0/0/1",
                     late_done, late_sel, fifo_count, req_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_fifo_full();
        test_back_to_back();
        test_timeout();
        test_decode_err();
        repeat (2) @(negedge PCLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected completions never seen, expected 0", sb.size());
        end
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
